alu_rr_scheduler: RTL

- Shares one external alu datapath (3-bit control, DATA_WIDTH_P operands, combinational result) among NUM_REQ_P requesters.
- Round-robin arbitration, per-requester valid/ready request handshake, single registered response channel tagged with requester id.
- Sits between issue logic/co-processors and the shared alu instance; owns the alu control and operand inputs exclusively.

---
 rtl/alu_rr_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that lets several requesters share one external ALU.
// Each accepted op runs as grant, EXEC, RESP; the response is tagged with the requester id.
module alu_rr_scheduler #(
  parameter int DATA_WIDTH_P  = 32,
  parameter int CNTRL_WIDTH_P = 3,
  parameter int NUM_REQ_P     = 4,
  parameter int ID_WIDTH_P    = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ_P-1:0]               i_req_valid,
  output logic [NUM_REQ_P-1:0]               o_req_ready,
  input  logic [NUM_REQ_P*CNTRL_WIDTH_P-1:0] i_req_op,
  input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0]  i_req_a,
  input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0]  i_req_b,
  output logic [CNTRL_WIDTH_P-1:0]           o_alu_control,
  output logic [DATA_WIDTH_P-1:0]            o_alu_a,
  output logic [DATA_WIDTH_P-1:0]            o_alu_b,
  input  logic [DATA_WIDTH_P-1:0]            i_alu_result,
  output logic                               o_rsp_valid,
  input  logic                               i_rsp_ready,
  output logic [ID_WIDTH_P-1:0]              o_rsp_id,
  output logic [DATA_WIDTH_P-1:0]            o_rsp_data,
  output logic                               o_rsp_err,
  output logic                               o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state, state_next;
  logic [ID_WIDTH_P-1:0]   rr_ptr;
  logic [ID_WIDTH_P-1:0]   lat_id;
  logic                    found;
  logic                    grant;
  logic [ID_WIDTH_P-1:0]   winner;
  logic [NUM_REQ_P-1:0]    win_onehot;
  logic [CNTRL_WIDTH_P-1:0] win_op;
  logic [DATA_WIDTH_P-1:0] win_a;
  logic [DATA_WIDTH_P-1:0] win_b;

  function automatic logic op_legal(input logic [CNTRL_WIDTH_P-1:0] op);
    logic legal;
    legal = 1'b0;
    if (op == CNTRL_WIDTH_P'(3'b010) || op == CNTRL_WIDTH_P'(3'b110) ||
        op == CNTRL_WIDTH_P'(3'b000) || op == CNTRL_WIDTH_P'(3'b001) ||
        op == CNTRL_WIDTH_P'(3'b111))
      legal = 1'b1;
    return legal;
  endfunction

  // Two passes give the rotated search: indices at/above rr_ptr first, then the wrapped ones.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    win_onehot = '0;
    win_op     = '0;
    win_a      = '0;
    win_b      = '0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      if (!found && k >= int'(rr_ptr) && i_req_valid[k]) begin
        found         = 1'b1;
        winner        = ID_WIDTH_P'(k);
        win_onehot[k] = 1'b1;
        win_op        = i_req_op[k*CNTRL_WIDTH_P +: CNTRL_WIDTH_P];
        win_a         = i_req_a[k*DATA_WIDTH_P +: DATA_WIDTH_P];
        win_b         = i_req_b[k*DATA_WIDTH_P +: DATA_WIDTH_P];
      end
    end
    for (int k = 0; k < NUM_REQ_P; k++) begin
      if (!found && k < int'(rr_ptr) && i_req_valid[k]) begin
        found         = 1'b1;
        winner        = ID_WIDTH_P'(k);
        win_onehot[k] = 1'b1;
        win_op        = i_req_op[k*CNTRL_WIDTH_P +: CNTRL_WIDTH_P];
        win_a         = i_req_a[k*DATA_WIDTH_P +: DATA_WIDTH_P];
        win_b         = i_req_b[k*DATA_WIDTH_P +: DATA_WIDTH_P];
      end
    end
  end

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    o_req_ready = '0;
    case (state)
      IDLE: begin
        if (found && !reset) begin
          grant       = 1'b1;
          o_req_ready = win_onehot;
          state_next  = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The latched operands double as the ALU drive, so they hold between ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      lat_id        <= '0;
      o_alu_control <= '0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_rsp_id      <= '0;
      o_rsp_data    <= '0;
      o_rsp_err     <= 1'b0;
    end else begin
      if (grant) begin
        lat_id        <= winner;
        o_alu_control <= win_op;
        o_alu_a       <= win_a;
        o_alu_b       <= win_b;
        rr_ptr        <= (winner == ID_WIDTH_P'(NUM_REQ_P-1)) ? '0 : winner + ID_WIDTH_P'(1);
      end
      if (state == EXEC) begin
        o_rsp_id <= lat_id;
        if (op_legal(o_alu_control)) begin
          o_rsp_data <= i_alu_result;
          o_rsp_err  <= 1'b0;
        end else begin
          o_rsp_data <= '0;
          o_rsp_err  <= 1'b1;
        end
      end
    end
  end

  assign o_rsp_valid = (state == RESP);
  assign o_busy      = (state != IDLE);

endmodule
